// File: rtl/fetch_fifo_if.sv
// rtl/fetch_fifo_if.sv - fetch_entry record type and the fetch/decode handshake bundle.
// master = fetch/decode side driving the queue, slave = fetch_fifo itself.
package fetch_fifo_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } fetch_ex_t;

  typedef struct packed {
    logic        bp_taken;
    fetch_ex_t   ex;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        is_compressed;
    logic        is_illegal;
  } fetch_entry;
endpackage

interface fetch_fifo_if #(
  parameter int DEPTH = 4
) ();
  logic                           flush_i;
  logic                           in_valid_i;
  logic                           in_ready_o;
  fetch_fifo_pkg::fetch_entry     in_entry_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  fetch_fifo_pkg::fetch_entry     out_entry_o;
  logic [$clog2(DEPTH+1)-1:0]     count_o;
  logic                           locked_o;

  modport master (
    output flush_i, in_valid_i, in_entry_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_entry_o, count_o, locked_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_entry_i, out_ready_i,
    output in_ready_o, out_valid_o, out_entry_o, count_o, locked_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch-to-decode instruction queue with exception lock and one-cycle flush.
// Optional same-cycle forwarding into an empty queue when FETCH_FIFO_BYPASS_EN is defined.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_fifo_if.slave  bus
);
  import fetch_fifo_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_fifo: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t     r_state;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  fetch_entry      r_mem [DEPTH];

  logic            w_empty;
  logic            w_in_ready;
  logic            w_push;
  logic            w_store;
  logic            w_drain;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count != FULL) && (r_state == ST_OPEN);
  assign w_push     = bus.in_valid_i & w_in_ready & ~bus.flush_i;
  assign w_drain    = ~w_empty & bus.out_ready_i & ~bus.flush_i;

`ifdef FETCH_FIFO_BYPASS_EN
  logic w_bypass;
  // A forwarded entry that decode takes immediately never touches storage.
  assign w_bypass        = w_empty & w_push;
  assign w_store         = w_push & ~(w_bypass & bus.out_ready_i);
  assign bus.out_valid_o = ~w_empty | w_bypass;
  assign bus.out_entry_o = w_bypass ? bus.in_entry_i : r_mem[r_rptr];
`else
  assign w_store         = w_push;
  assign bus.out_valid_o = ~w_empty;
  assign bus.out_entry_o = r_mem[r_rptr];
`endif

  assign bus.in_ready_o = w_in_ready;
  assign bus.count_o    = r_count;
  assign bus.locked_o   = (r_state == ST_LOCKED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_state <= ST_OPEN;
    end else if (bus.flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_state <= ST_OPEN;
    end else begin
      if (w_store) r_wptr <= r_wptr + PW'(1);
      if (w_drain) r_rptr <= r_rptr + PW'(1);
      case ({w_store, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Lock on any accepted faulting fetch, including one forwarded straight through.
      if (w_push && bus.in_entry_i.ex.valid) r_state <= ST_LOCKED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) r_mem[r_wptr] <= bus.in_entry_i;
  end
endmodule

// File: doc/fetch_fifo.md
# fetch_fifo

Instruction queue between the fetch stage and the decode stage. It buffers `fetch_entry` records (branch-predict hint, exception, address, instruction, compressed/illegal flags) using valid/ready handshakes on both sides. A fetch exception locks the input, so no instruction past a faulting fetch is accepted until the pipeline flushes. `flush_i` empties the queue in one cycle on mispredict, exception commit or `fence.i`.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `clk_i` in, 1: clock; all state updates on the rising edge.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `flush_i` in, 1: drop all stored entries and the pending push; clear the lock.
- `in_valid_i` in, 1: fetch offers `in_entry_i`.
- `in_ready_o` out, 1: FIFO accepts `in_entry_i` this cycle.
- `in_entry_i` in, `$bits(fetch_entry)`: entry from fetch.
- `out_valid_o` out, 1: `out_entry_o` holds the head entry.
- `out_ready_i` in, 1: decode consumes the head this cycle.
- `out_entry_o` out, `$bits(fetch_entry)`: head entry.
- `count_o` out, `$clog2(DEPTH+1)`: number of stored entries.
- `locked_o` out, 1: an exception entry has been accepted and input is blocked.

## Operation
- Storage is a circular buffer of `DEPTH` entries with a read pointer, a write pointer and a counter.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap from `DEPTH-1` to 0 naturally.
  - The counter is `$clog2(DEPTH+1)` bits wide.
- Push = `in_valid_i & in_ready_o & ~flush_i`. It writes the entry at the write pointer and increments the write pointer.
- Pop = `out_valid_o & out_ready_i & ~flush_i`. It increments the read pointer.
- Count update: `count_o` goes up by 1 on push only, down by 1 on pop only, and is unchanged when push and pop happen together.
- `in_ready_o = (count_o != DEPTH) & ~locked_o`. It depends on registered state only and never on `in_valid_i` or `out_ready_i`.
- When full, a same-cycle pop does not raise `in_ready_o`; there is no full-pass-through.
- `out_valid_o = (count_o != 0)`. `out_entry_o` is the entry at the read pointer, read combinationally from storage.
- Lock state machine:
  - States are OPEN and LOCKED.
  - OPEN→LOCKED on a push with `in_entry_i.ex.valid = 1`.
  - LOCKED→OPEN on `flush_i`.
  - In LOCKED the entries already stored still drain normally.
  - `locked_o = 1` in LOCKED.
- Flush:
  - Next edge: pointers = 0, count = 0, state = OPEN.
  - The push and pop attempted in the flush cycle are discarded; decode must ignore `out_entry_o` during flush.
- Simultaneous flush and exception push: flush wins and the state stays OPEN.
- Storage contents are not reset; only pointers, count and state are reset.
- Reset values: `count_o = 0`, `out_valid_o = 0`, `in_ready_o = 1`, `locked_o = 0`, pointers = 0, state = OPEN.

## Timing
- Latency without bypass: an entry pushed at edge N is visible on `out_*` in the cycle after edge N, so the minimum latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle while `0 < count_o < DEPTH`.
- `out_entry_o` and `out_valid_o` do not change while `out_valid_o & ~out_ready_i & ~flush_i` holds (stable-until-accepted).
- Async reset assertion forces all reset values immediately, independent of the clock. Deassertion is assumed synchronous to `clk_i`.
- Reset in the middle of operation drops all entries and the lock with no handshake side effects.

## Configuration
- `FETCH_FIFO_BYPASS_EN` defined: when `count_o == 0` and `in_valid_i & in_ready_o`, the FIFO forwards the input combinationally in the same cycle.
  - `out_valid_o = 1` and `out_entry_o = in_entry_i`.
  - If `out_ready_i = 1` the entry is not written and the count stays 0.
  - An exception entry accepted this way still sets LOCKED.
  - Flush in the same cycle suppresses the bypass and forces `out_valid_o = 0`.
- Not defined: no bypass; `out_*` is driven from storage only and the minimum latency is 1 cycle.

## Test plan
- Reset then fill: hold `out_ready_i = 0` and push addresses 0x80, 0x84, 0x88, 0x8C (`DEPTH = 4`).
  - Required: `count_o = 4`, `in_ready_o = 0`, head address = 0x80.
- Stream: `in_valid_i = out_ready_i = 1` for 20 cycles with addresses 0x1000 + 4k.
  - Required: outputs in order with no gaps after the first, pointers wrap, `count_o` stays at 1 (0 with bypass).
- Exception lock: push 0x200, then 0x204 with `ex.valid = 1` and cause 12, then offer 0x208.
  - Required: `locked_o = 1`, 0x208 is never accepted, 0x200 and 0x204 drain, `in_ready_o` stays 0 until flush.
- Flush while full and locked, with push attempted in the same cycle.
  - Required next cycle: `count_o = 0`, `out_valid_o = 0`, `locked_o = 0`, `in_ready_o = 1`.
- Full plus simultaneous pop: `count_o = 4`, `out_ready_i = 1`, `in_valid_i = 1`.
  - Required: no push, `count_o = 3`.
  - Next cycle: push accepted and `count_o` stays 3 with pop.
- Async reset pulse mid-cycle while `count_o = 2`.
  - Required: outputs reach reset values before the next edge.
  - Following pushes start at entry 0.
